uart_receiver: RTL and testbench
================================

# uart_receiver

UART receiver for the Master_Control host link: the inbound counterpart of the existing transmitter path. Recovers 8N1 frames (start bit 0, eight data bits LSB first, stop bit 1, line idle high) from the asynchronous RxD pin. Samples with a 16x-baud enable and delivers each byte with a one-cycle valid strobe to the command decoder.

## Interface
- OVERSAMPLE, 16, rx_tick pulses per bit period; even, ≥ 4.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_tick  in  1  one-cycle enable at OVERSAMPLE × baud, from the shared baud generator.
- RxD  in  1  serial line, asynchronous to clk, idle high.
- RxD_Data  out  8  last correctly framed byte; holds until the next good frame.
- data_valid  out  1  one-cycle pulse: RxD_Data just updated.
- frame_error  out  1  one-cycle pulse: stop bit sampled 0.
- busy  out  1  high in every FSM state except IDLE.

## Operation
- RxD passes a 2-FF synchronizer; both flops reset to 1. All logic uses the synchronized value rxs.
- Tick counter (log2 OVERSAMPLE bits) advances only on rx_tick. Bit counter is 3 bits, counting down from 7 as in the transmitter.
- FSM states:
  - IDLE: on rx_tick with rxs=0, clear the tick counter and go to START.
  - START: on the (OVERSAMPLE/2)-th rx_tick, re-sample.
    - rxs=1: glitch; return to IDLE with no output.
    - rxs=0: clear the tick counter, set the bit counter to 7, go to DATA.
  - DATA: every OVERSAMPLE-th rx_tick (mid-bit), shift rxs into the shift register MSB: sr <= {rxs, sr[7:1]}. After the sample taken with the bit counter at 0, go to STOP; otherwise decrement.
  - STOP: on the OVERSAMPLE-th rx_tick, sample rxs.
    - rxs=1: load RxD_Data <= sr, pulse data_valid, go to IDLE.
    - rxs=0: pulse frame_error, leave RxD_Data unchanged, go to BREAK.
  - BREAK: wait for rxs=1 sampled on an rx_tick, then go to IDLE. This prevents a held-low line from generating back-to-back frames.
- No rx_tick means no state progress. rxs changes between ticks are ignored.
- Reset at any point: FSM to IDLE, counters cleared, any partial frame discarded.

## Timing
- Reset values: RxD_Data=8'h00, data_valid=0, frame_error=0, busy=0, shift register 8'h00.
- All outputs are registered.
- data_valid and frame_error rise on the clk edge after the stop-bit sampling tick. Each is high for exactly one clk.
- Nominal frame latency, from the falling edge at the pin to data_valid: 2 clk synchronizer, plus at most 1 tick detection jitter, plus 9.5 bit periods, plus 1 clk.
- Next frame: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is detected (half-bit margin).
- Accepted baud mismatch: ±(OVERSAMPLE/2 − 1)/(10·OVERSAMPLE), about ±4.4% at 16.
- data_valid and frame_error are never high together. Neither is asserted in IDLE, START or BREAK.
- There is no back-pressure. The consumer must capture RxD_Data on data_valid. A later good frame overwrites it.

## Structure
- Shared package/include: 8N1 constants (DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1) and state encodings, so the transmitter control can share them.
- One sub-module, receiver_dp: synchronizer, shift register, tick counter, bit counter, output registers. Its control inputs (clr_tick, set_count, shift, load_data) mirror the transmitter datapath split.
- FSM lives in uart_receiver.

## Test plan
- Good frame 0xA5 at OVERSAMPLE=16, rx_tick every 4 clk -> exactly one data_valid pulse; RxD_Data=8'hA5; frame_error stays 0; busy falls with the pulse.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses, values 8'h00 and 8'hFF in order.
- Low glitch of 3 rx_ticks on an idle line -> return to IDLE at the mid-start check; no output pulse.
- Frame 0x3C with stop bit forced 0 and the line then held low for 20 bit times -> one frame_error pulse; RxD_Data keeps its previous value; no further pulses until the line goes high and a new valid frame 0x55 yields data_valid with 8'h55.
- rst_n asserted at data bit 4 of a frame -> all outputs return to reset values immediately (async). After release, the following clean frame 0x81 is received correctly.
- Transmitter at +4% and −4% baud sending 0x6E -> received as 8'h6E with no frame_error.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared 8N1 framing constants and receiver state encodings.
// Kept in a package so the transmitter control can use the same definitions.
package uart_receiver_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_dp.sv
// Receiver datapath: RxD synchronizer, tick/bit counters, shift register and
// registered outputs. All sequencing decisions come from the FSM in uart_receiver.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rx_tick_i           16x-baud enable
//   rxd_i               raw serial line
//   clr_tick_i          clear tick counter
//   set_count_i         load bit counter with DATA_BITS-1
//   shift_i             shift rxs into shift register MSB, decrement bit counter
//   load_data_i         copy shift register to output, pulse data_valid
//   frame_err_i         pulse frame_error
//   busy_d_i            next value of busy
//   rxs_o               synchronized line
//   tick_cnt_o/bit_cnt_o counter values for the FSM
//   rx_data_o, data_valid_o, frame_error_o, busy_o   registered outputs
module receiver_dp
    import uart_receiver_pkg::*;
#(
    parameter int unsigned TICK_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick_i,
    input  logic                 rxd_i,
    input  logic                 clr_tick_i,
    input  logic                 set_count_i,
    input  logic                 shift_i,
    input  logic                 load_data_i,
    input  logic                 frame_err_i,
    input  logic                 busy_d_i,
    output logic                 rxs_o,
    output logic [TICK_W-1:0]    tick_cnt_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 data_valid_o,
    output logic                 frame_error_o,
    output logic                 busy_o
);

    logic                 sync1_q, sync2_q;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, fe_q, busy_q;

    // Next-state logic for counters, shift register and data output
    always_comb begin
        tick_d = tick_q;
        bit_d  = bit_q;
        sr_d   = sr_q;
        data_d = data_q;
        if (clr_tick_i) begin
            tick_d = '0;
        end else if (rx_tick_i) begin
            tick_d = tick_q + TICK_W'(1);
        end
        if (set_count_i) begin
            bit_d = BIT_CNT_W'(DATA_BITS - 1);
        end else if (shift_i) begin
            bit_d = bit_q - BIT_CNT_W'(1);
        end
        if (shift_i) begin
            sr_d = {sync2_q, sr_q[DATA_BITS-1:1]};
        end
        if (load_data_i) begin
            data_d = sr_q;
        end
    end

    // Synchronizer flops reset to the idle level so reset release is not a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            dv_q    <= load_data_i;
            fe_q    <= frame_err_i;
            busy_q  <= busy_d_i;
        end
    end

    assign rxs_o         = sync2_q;
    assign tick_cnt_o    = tick_q;
    assign bit_cnt_o     = bit_q;
    assign rx_data_o     = data_q;
    assign data_valid_o  = dv_q;
    assign frame_error_o = fe_q;
    assign busy_o        = busy_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x (OVERSAMPLE) tick sampling and one-cycle byte strobe.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   rx_tick       OVERSAMPLE x baud enable
//   RxD           serial line, idle high, asynchronous
//   RxD_Data      last correctly framed byte
//   data_valid    one-cycle pulse when RxD_Data updates
//   frame_error   one-cycle pulse when the stop bit is sampled low
//   busy          high whenever the FSM is not idle
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_tick,
    input  logic       RxD,
    output logic [7:0] RxD_Data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

    rx_state_e            state_q, state_d;
    logic                 rxs;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 clr_tick, set_count, shift, load_data, frame_err, busy_d;
    logic                 half_hit, full_hit;

    // Tick counter is cleared on the qualifying tick, so value N-1 marks the N-th tick
    assign half_hit = rx_tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
    assign full_hit = rx_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        clr_tick  = 1'b0;
        set_count = 1'b0;
        shift     = 1'b0;
        load_data = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_tick && (rxs == START_LEVEL)) begin
                    clr_tick = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (half_hit) begin
                    if (rxs == START_LEVEL) begin
                        clr_tick  = 1'b1;
                        set_count = 1'b1;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (full_hit) begin
                    clr_tick = 1'b1;
                    shift    = 1'b1;
                    if (bit_cnt == '0) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (full_hit) begin
                    clr_tick = 1'b1;
                    if (rxs == STOP_LEVEL) begin
                        load_data = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line is seen high, so a stuck-low line yields one error
                if (rx_tick && (rxs == STOP_LEVEL)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    receiver_dp #(
        .TICK_W (TICK_W)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_tick_i     (rx_tick),
        .rxd_i         (RxD),
        .clr_tick_i    (clr_tick),
        .set_count_i   (set_count),
        .shift_i       (shift),
        .load_data_i   (load_data),
        .frame_err_i   (frame_err),
        .busy_d_i      (busy_d),
        .rxs_o         (rxs),
        .tick_cnt_o    (tick_cnt),
        .bit_cnt_o     (bit_cnt),
        .rx_data_o     (RxD_Data),
        .data_valid_o  (data_valid),
        .frame_error_o (frame_error),
        .busy_o        (busy)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: rx_tick every 4 clk, nominal bit time 640 time units.
module tb_uart_receiver;

    localparam int BIT_NOM  = 640;
    localparam int BIT_FAST = 615;
    localparam int BIT_SLOW = 667;

    logic       clk;
    logic       rst_n;
    logic       rx_tick;
    logic       RxD;
    logic [7:0] RxD_Data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int         dv_cnt      = 0;
    int         fe_cnt      = 0;
    int         both_cnt    = 0;
    int         long_cnt    = 0;
    int         busy_dv_cnt = 0;
    logic       dv_prev     = 1'b0;
    logic       fe_prev     = 1'b0;
    logic [7:0] dv_hist[$];

    uart_receiver #(
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_tick     (rx_tick),
        .RxD         (RxD),
        .RxD_Data    (RxD_Data),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_tick = 1'b1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        dv_prev <= data_valid;
        fe_prev <= frame_error;
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_hist.push_back(RxD_Data);
            if (busy) busy_dv_cnt <= busy_dv_cnt + 1;
        end
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (data_valid && frame_error) both_cnt <= both_cnt + 1;
        if ((data_valid && dv_prev) || (frame_error && fe_prev)) long_cnt <= long_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level (left on the line)
    task automatic send_byte(input logic [7:0] b, input int bit_t, input logic stop);
        RxD = 1'b0;
        #bit_t;
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #bit_t;
        end
        RxD = stop;
        #bit_t;
    endtask

    initial begin
        int dv0;
        int fe0;
        int hb;
        rst_n = 1'b0;
        RxD   = 1'b1;
        #23;
        check("reset_data", 32'(RxD_Data), 32'h00);
        check("reset_dv", 32'(data_valid), 32'h0);
        check("reset_fe", 32'(frame_error), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        #1000;

        // Good frame 0xA5
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'hA5, BIT_NOM, 1'b1);
        #1000;
        check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("a5_data", 32'(RxD_Data), 32'hA5);
        check("a5_fe_count", 32'(fe_cnt - fe0), 32'd0);
        check("a5_busy_idle", 32'(busy), 32'h0);
        check("a5_busy_at_dv", 32'(busy_dv_cnt), 32'd0);

        // Back-to-back 0x00, 0xFF
        dv0 = dv_cnt; hb = dv_hist.size();
        send_byte(8'h00, BIT_NOM, 1'b1);
        send_byte(8'hFF, BIT_NOM, 1'b1);
        #1000;
        check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_first", 32'(dv_hist[hb]), 32'h00);
        check("b2b_second", 32'(dv_hist[hb + 1]), 32'hFF);

        // Low glitch of 3 rx_ticks
        dv0 = dv_cnt; fe0 = fe_cnt;
        RxD = 1'b0;
        #120;
        RxD = 1'b1;
        #30;
        check("glitch_busy_start", 32'(busy), 32'h1);
        #1000;
        check("glitch_busy_idle", 32'(busy), 32'h0);
        check("glitch_dv_count", 32'(dv_cnt - dv0), 32'd0);
        check("glitch_fe_count", 32'(fe_cnt - fe0), 32'd0);

        // 0x3C with bad stop bit, line held low for 20 bit times
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h3C, BIT_NOM, 1'b0);
        #(20 * BIT_NOM);
        check("ferr_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_dv_count", 32'(dv_cnt - dv0), 32'd0);
        check("ferr_data_kept", 32'(RxD_Data), 32'hFF);
        check("ferr_busy_break", 32'(busy), 32'h1);
        RxD = 1'b1;
        #(2 * BIT_NOM);
        check("ferr_busy_release", 32'(busy), 32'h0);
        send_byte(8'h55, BIT_NOM, 1'b1);
        #1000;
        check("recover_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("recover_data", 32'(RxD_Data), 32'h55);
        check("recover_fe_count", 32'(fe_cnt - fe0), 32'd1);

        // Reset in the middle of data bit 4
        RxD = 1'b0;
        #BIT_NOM;
        for (int i = 0; i < 4; i++) begin
            RxD = i[0];
            #BIT_NOM;
        end
        RxD = 1'b1;
        #(BIT_NOM / 2);
        check("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(RxD_Data), 32'h00);
        check("midrst_dv", 32'(data_valid), 32'h0);
        check("midrst_fe", 32'(frame_error), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        #1000;
        rst_n = 1'b1;
        #(2 * BIT_NOM);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h81, BIT_NOM, 1'b1);
        #1000;
        check("post_rst_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("post_rst_data", 32'(RxD_Data), 32'h81);

        // Baud mismatch, about +4% then -4%
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h6E, BIT_FAST, 1'b1);
        #1000;
        check("fast_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("fast_data", 32'(RxD_Data), 32'h6E);
        check("fast_fe_count", 32'(fe_cnt - fe0), 32'd0);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h91, BIT_NOM, 1'b1);
        #1000;
        check("between_data", 32'(RxD_Data), 32'h91);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_byte(8'h6E, BIT_SLOW, 1'b1);
        #1000;
        check("slow_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("slow_data", 32'(RxD_Data), 32'h6E);
        check("slow_fe_count", 32'(fe_cnt - fe0), 32'd0);

        check("pulses_exclusive", 32'(both_cnt), 32'd0);
        check("pulses_single_cycle", 32'(long_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
